// File: rtl/pd_stimulus_gen.sv
// ----------------------------------------------------------------------------
// pd_stimulus_gen
//
// Stimulus generator and scoreboard for the multiply/pattern-detect block.
// Each run drives a stream of operand pairs on A/B, starting from seed_a and
// seed_b. It also drives a comparison pattern that the detector should either
// match or miss. It then checks the returned product C and match flag ones_o
// against its own A*B model.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   start               begin a run (sampled only when idle)
//   num_vec             number of vectors in the run (0..255)
//   seed_a, seed_b      first operand values of the run
//   mode                0 = match, 1 = miss, 2 = alternate, 3 = same as 0
//   A, B, pd_pattern1   registered operands and pattern to the detector
//   C, ones_o           product and match flag returned by the detector
//   busy                high while vectors are driven or results are pending
//   done                one-cycle pulse at the end of a run
//   hit_cnt, err_cnt    saturating counts of matches and of bad result slots
// ----------------------------------------------------------------------------
module pd_stimulus_gen #(
    parameter int input_1_width = 10,
    parameter int input_2_width = 10,
    parameter int output_width  = 20,
    parameter int DET_LAT       = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [7:0]               num_vec,
    input  logic [input_1_width:0]   seed_a,
    input  logic [input_2_width:0]   seed_b,
    input  logic [1:0]               mode,
    output logic [input_1_width:0]   A,
    output logic [input_2_width:0]   B,
    output logic [output_width:0]    pd_pattern1,
    input  logic [output_width:0]    C,
    input  logic                     ones_o,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               hit_cnt,
    output logic [7:0]               err_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int          PW         = input_1_width + input_2_width + 2;
    localparam logic [2:0]  DRAIN_LAST = 3'(DET_LAT - 1);

    logic [1:0]             state;
    logic [2:0]             drain_cnt;
    logic [7:0]             idx;
    logic [7:0]             num_vec_r;
    logic [1:0]             mode_r;
    logic                   exp_ones_r;

    logic                   start_acc;
    logic                   accept;
    logic                   advance;
    logic                   last_vec;
    logic [input_1_width:0] nxt_a;
    logic [input_2_width:0] nxt_b;
    logic [7:0]             nxt_idx;
    logic [1:0]             eff_mode;
    logic [output_width:0]  nxt_p;
    logic                   nxt_inv;

    logic                   dl_valid [DET_LAT];
    logic [output_width:0]  dl_c     [DET_LAT];
    logic                   dl_ones  [DET_LAT];

    logic                   chk_valid;
    logic                   chk_err;

    // Low output_width+1 bits of the full-width product; the top bit of the
    // full product is intentionally dropped.
    function automatic logic [output_width:0] prod(
        input logic [input_1_width:0] a,
        input logic [input_2_width:0] b
    );
        return (output_width + 1)'(PW'(a) * PW'(b));
    endfunction

    assign start_acc = (state == ST_IDLE) && start;
    assign accept    = start_acc && (num_vec != 8'd0);
    assign last_vec  = (idx == 8'(num_vec_r - 8'd1));
    assign advance   = (state == ST_RUN) && !last_vec;

    assign busy = (state == ST_RUN) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);

    // Next vector: seeds on start, otherwise A+1 / B+3 with natural
    // wrap-around. The pattern is derived from the product of the next
    // operands. The mode is taken live on the start cycle and from the
    // latched copy afterwards.
    always_comb begin
        nxt_a    = A;
        nxt_b    = B;
        nxt_idx  = idx;
        if (accept) begin
            nxt_a   = seed_a;
            nxt_b   = seed_b;
            nxt_idx = 8'd0;
        end else if (advance) begin
            nxt_a   = A + (input_1_width + 1)'(1);
            nxt_b   = B + (input_2_width + 1)'(3);
            nxt_idx = idx + 8'd1;
        end
        eff_mode = accept ? mode : mode_r;
        nxt_p    = prod(nxt_a, nxt_b);
        case (eff_mode)
            2'd1:    nxt_inv = 1'b1;
            2'd2:    nxt_inv = nxt_idx[0];
            default: nxt_inv = 1'b0;
        endcase
    end

    // Run sequencing. RUN lasts one cycle per vector. DRAIN waits out the
    // detector latency so that the last result gets checked before done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            drain_cnt <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= (num_vec != 8'd0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (last_vec) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 3'd0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Operand, pattern and vector-index registers. These hold their values
    // once a run ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A           <= '0;
            B           <= '0;
            pd_pattern1 <= '0;
            exp_ones_r  <= 1'b0;
            idx         <= 8'd0;
            num_vec_r   <= 8'd0;
            mode_r      <= 2'd0;
        end else begin
            if (accept) begin
                num_vec_r <= num_vec;
                mode_r    <= mode;
            end
            if (accept || advance) begin
                A           <= nxt_a;
                B           <= nxt_b;
                idx         <= nxt_idx;
                pd_pattern1 <= nxt_inv ? ~nxt_p : nxt_p;
                exp_ones_r  <= ~nxt_inv;
            end
        end
    end

    // Expected-result delay line. A slot is pushed for every cycle in which
    // a valid vector is on A/B. The oldest slot lines up with the detector
    // output for that vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DET_LAT; k++) begin
                dl_valid[k] <= 1'b0;
                dl_c[k]     <= '0;
                dl_ones[k]  <= 1'b0;
            end
        end else begin
            for (int k = DET_LAT - 1; k > 0; k--) begin
                dl_valid[k] <= dl_valid[k-1];
                dl_c[k]     <= dl_c[k-1];
                dl_ones[k]  <= dl_ones[k-1];
            end
            dl_valid[0] <= (state == ST_RUN);
            dl_c[0]     <= prod(A, B);
            dl_ones[0]  <= exp_ones_r;
        end
    end

    assign chk_valid = dl_valid[DET_LAT-1];
    assign chk_err   = (C != dl_c[DET_LAT-1]) || (ones_o != dl_ones[DET_LAT-1]);

    // Saturating scoreboard counters. They clear on any start accepted in
    // IDLE, including a zero-length run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt <= 8'd0;
            err_cnt <= 8'd0;
        end else if (start_acc) begin
            hit_cnt <= 8'd0;
            err_cnt <= 8'd0;
        end else if (chk_valid) begin
            if (ones_o && (hit_cnt != 8'hFF)) begin
                hit_cnt <= hit_cnt + 8'd1;
            end
            if (chk_err && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pd_stimulus_gen.sv
// ----------------------------------------------------------------------------
// tb_pd_stimulus_gen
//
// Directed bench for pd_stimulus_gen. It contains a one-cycle detector model
// (registered product and pattern compare) whose match flag can be forced
// low. The bench runs hand-computed vectors through the generator.
// ----------------------------------------------------------------------------
module tb_pd_stimulus_gen;

    localparam int DET_LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  num_vec = 8'd0;
    logic [10:0] seed_a = 11'd0;
    logic [10:0] seed_b = 11'd0;
    logic [1:0]  mode = 2'd0;
    logic [10:0] A;
    logic [10:0] B;
    logic [20:0] pd_pattern1;
    logic [20:0] C = 21'd0;
    logic        ones_o = 1'b0;
    logic        busy;
    logic        done;
    logic [7:0]  hit_cnt;
    logic [7:0]  err_cnt;

    logic        tie_ones0 = 1'b0;
    logic [21:0] full_prod;

    int nCompared = 0;
    int nMismatched = 0;

    int latency;
    int busyCnt;
    int doneCnt;
    int finalHit;
    int finalErr;
    int aSeq [16];
    int bSeq [16];
    int pSeq [16];
    int cArr [16];

    pd_stimulus_gen #(
        .input_1_width(10),
        .input_2_width(10),
        .output_width (20),
        .DET_LAT      (DET_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_vec    (num_vec),
        .seed_a     (seed_a),
        .seed_b     (seed_b),
        .mode       (mode),
        .A          (A),
        .B          (B),
        .pd_pattern1(pd_pattern1),
        .C          (C),
        .ones_o     (ones_o),
        .busy       (busy),
        .done       (done),
        .hit_cnt    (hit_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    // Detector model with a one-cycle latency. The match flag can be forced
    // low to provoke scoreboard errors.
    assign full_prod = {11'd0, A} * {11'd0, B};
    always @(posedge clk) begin
        C      <= full_prod[20:0];
        ones_o <= tie_ones0 ? 1'b0 : (full_prod[20:0] == pd_pattern1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starts one run and observes a bounded window after the start edge.
    // Sample n is taken 1 time unit after the n-th posedge (edge 0 is the
    // start edge). A start pulse can be injected at sample pulseAt.
    task automatic applyStimulus(input int sa, input int sb, input int nv, input int md, input int pulseAt);
        @(negedge clk);
        seed_a  = 11'(sa);
        seed_b  = 11'(sb);
        num_vec = 8'(nv);
        mode    = 2'(md);
        start   = 1'b1;
        @(posedge clk);
        #1;
        latency  = 0;
        busyCnt  = 0;
        doneCnt  = 0;
        finalHit = -1;
        finalErr = -1;
        for (int n = 0; n < nv + DET_LAT + 4; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            start = (n == pulseAt);
            if (busy) busyCnt++;
            if (done) begin
                doneCnt++;
                if (latency == 0) begin
                    latency  = n + 1;
                    finalHit = int'(hit_cnt);
                    finalErr = int'(err_cnt);
                end
            end
            if (n < 16) begin
                aSeq[n] = int'(A);
                bSeq[n] = int'(B);
                pSeq[n] = int'(pd_pattern1);
                cArr[n] = int'(C);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_A", 32'(A), 0);
        checkOutput("rst_B", 32'(B), 0);
        checkOutput("rst_pat", 32'(pd_pattern1), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_hit", 32'(hit_cnt), 0);
        checkOutput("rst_err", 32'(err_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single vector, match mode: 12*2 = 24
        applyStimulus(12, 2, 1, 0, -1);
        checkOutput("t1_A0", 32'(aSeq[0]), 12);
        checkOutput("t1_B0", 32'(bSeq[0]), 2);
        checkOutput("t1_pat0", 32'(pSeq[0]), 24);
        checkOutput("t1_C0", 32'(cArr[1]), 24);
        checkOutput("t1_latency", 32'(latency), 3);
        checkOutput("t1_busy_cycles", 32'(busyCnt), 2);
        checkOutput("t1_done_pulses", 32'(doneCnt), 1);
        checkOutput("t1_hit", 32'(finalHit), 1);
        checkOutput("t1_err", 32'(finalErr), 0);

        // Miss mode with A and B wrapping
        applyStimulus(2046, 2045, 4, 1, -1);
        checkOutput("t2_A0", 32'(aSeq[0]), 2046);
        checkOutput("t2_A1", 32'(aSeq[1]), 2047);
        checkOutput("t2_A2", 32'(aSeq[2]), 0);
        checkOutput("t2_A3", 32'(aSeq[3]), 1);
        checkOutput("t2_B1", 32'(bSeq[1]), 0);
        checkOutput("t2_B2", 32'(bSeq[2]), 3);
        checkOutput("t2_B3", 32'(bSeq[3]), 6);
        checkOutput("t2_pat0", 32'(pSeq[0]), 10233);
        checkOutput("t2_pat1", 32'(pSeq[1]), 2097151);
        checkOutput("t2_hit", 32'(finalHit), 0);
        checkOutput("t2_err", 32'(finalErr), 0);
        checkOutput("t2_latency", 32'(latency), 6);

        // Alternate mode: products 35,60,91,128,171
        applyStimulus(5, 7, 5, 2, -1);
        checkOutput("t3_pat0", 32'(pSeq[0]), 35);
        checkOutput("t3_pat1", 32'(pSeq[1]), 2097091);
        checkOutput("t3_pat3", 32'(pSeq[3]), 2097023);
        checkOutput("t3_pat4", 32'(pSeq[4]), 171);
        checkOutput("t3_hit", 32'(finalHit), 3);
        checkOutput("t3_err", 32'(finalErr), 0);

        // Detector flag stuck low
        tie_ones0 = 1'b1;
        applyStimulus(3, 4, 3, 0, -1);
        checkOutput("t4_hit", 32'(finalHit), 0);
        checkOutput("t4_err", 32'(finalErr), 3);

        applyStimulus(1, 1, 255, 0, -1);
        checkOutput("t5_err_sat", 32'(finalErr), 255);
        checkOutput("t5_hit", 32'(finalHit), 0);
        checkOutput("t5_busy_cycles", 32'(busyCnt), 256);
        tie_ones0 = 1'b0;

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        seed_a  = 11'd100;
        seed_b  = 11'd200;
        num_vec = 8'd5;
        mode    = 2'd0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkOutput("t6_A_idx2", 32'(A), 102);
        checkOutput("t6_hit_mid", 32'(hit_cnt), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_A", 32'(A), 0);
        checkOutput("t6_rst_B", 32'(B), 0);
        checkOutput("t6_rst_pat", 32'(pd_pattern1), 0);
        checkOutput("t6_rst_busy", 32'(busy), 0);
        checkOutput("t6_rst_hit", 32'(hit_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(100, 200, 2, 0, -1);
        checkOutput("t6_hit", 32'(finalHit), 2);
        checkOutput("t6_err", 32'(finalErr), 0);
        checkOutput("t6_done_pulses", 32'(doneCnt), 1);

        // Start pulsed while busy is ignored
        applyStimulus(9, 9, 3, 0, 1);
        checkOutput("t7_done_pulses", 32'(doneCnt), 1);
        checkOutput("t7_busy_cycles", 32'(busyCnt), 4);
        checkOutput("t7_hit", 32'(finalHit), 3);
        checkOutput("t7_err", 32'(finalErr), 0);

        // Zero-length run
        applyStimulus(7, 7, 0, 0, -1);
        checkOutput("t8_latency", 32'(latency), 1);
        checkOutput("t8_busy_cycles", 32'(busyCnt), 0);
        checkOutput("t8_done_pulses", 32'(doneCnt), 1);
        checkOutput("t8_hit", 32'(finalHit), 0);
        checkOutput("t8_err", 32'(finalErr), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/pd_stimulus_gen.md
# pd_stimulus_gen

Self-checking stimulus generator and scoreboard for the multiply/pattern-detect block (`Pattern_detect`). It produces the operand stream on A/B and the comparison value on pd_pattern1. It consumes C/ones_o back from the detector and checks every result against its own A*B model. It replaces hand-written operand loads and gives the FPGA top a single start/done interface for on-board self-test.

## Interface
- input_1_width, 10, MSB index of A (A is [input_1_width:0], 11 bits)
- input_2_width, 10, MSB index of B
- output_width, 20, MSB index of C and pd_pattern1
- DET_LAT, 1, detector latency in cycles from A/B/pd_pattern1 to C/ones_o (1..4)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled only in IDLE
- num_vec  in  8  vectors per run (0..255)
- seed_a  in  input_1_width+1  first A value
- seed_b  in  input_2_width+1  first B value
- mode  in  2  pattern mode: 0 = match, 1 = miss, 2 = alternate, 3 = treated as 0
- A  out  input_1_width+1  operand to detector, registered
- B  out  input_2_width+1  operand to detector, registered
- pd_pattern1  out  output_width+1  pattern to detector, registered
- C  in  output_width+1  detector product
- ones_o  in  1  detector match flag
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at end of run
- hit_cnt  out  8  count of sampled ones_o=1
- err_cnt  out  8  count of mismatching result slots

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start=1 with num_vec != 0.
- IDLE -> DONE on start=1 with num_vec = 0.
- RUN -> DRAIN after the last vector has been presented for one cycle.
- DRAIN -> DONE after DET_LAT cycles.
- DONE -> IDLE unconditionally.
- start is ignored outside IDLE.
- At start acceptance:
  - hit_cnt and err_cnt clear to 0.
  - A <= seed_a, B <= seed_b, and pd_pattern1 is loaded for vector 0.
  - Vector index idx <= 0.
- Each further RUN cycle advances the vector:
  - A <= A+1, wrapping mod 2^(input_1_width+1), so 2047 -> 0.
  - B <= B+3, wrapping mod 2^(input_2_width+1).
  - idx <= idx+1.
- Expected product P = low output_width+1 bits of the full A*B product (22 bits at default widths; upper bit dropped).
- Pattern per vector:
  - mode 0: pd_pattern1 = P, expected ones = 1.
  - mode 1: pd_pattern1 = ~P, expected ones = 0.
  - mode 2: even idx uses P, odd idx uses ~P.
- Scoreboard:
  - A valid/expected-C/expected-ones delay line of depth DET_LAT tracks each vector.
  - On each valid slot, hit_cnt increments if ones_o = 1.
  - On each valid slot, err_cnt increments if C != expected P or ones_o != expected ones.
  - Both counters saturate at 255.
- A, B and pd_pattern1 hold their last values after a run.

## Timing
- Reset (asynchronous, any state, including mid-run):
  - State goes to IDLE.
  - A, B, pd_pattern1, hit_cnt and err_cnt go to 0; busy = 0, done = 0.
  - The delay line is cleared (all valid bits 0).
- Vector i is driven during cycle s+i, where s is the first cycle after the start edge.
- The result for vector i is sampled at the end of cycle s+i+DET_LAT.
- busy rises in cycle s and stays high for num_vec+DET_LAT cycles.
- done is high for exactly one cycle, the one after busy falls. hit_cnt and err_cnt are final during that cycle and hold until the next accepted start.
- With num_vec = 0: done pulses the cycle after start, counters are 0, and busy never rises.
- Total run latency from start edge to done = num_vec+DET_LAT+1 cycles.
- start held high through DONE does not start a new run until the FSM is back in IDLE, one cycle after done.

## Test plan
- seed_a=12, seed_b=2, num_vec=1, mode=0, DET_LAT=1 with the detector connected -> A=12, B=2, pd_pattern1=24, C=24; done 3 cycles after start; hit_cnt=1, err_cnt=0.
- seed_a=2046, seed_b=2045, num_vec=4, mode=1 -> A sequence 2046, 2047, 0, 1 (wrap); B sequence 2045, 2048 mod 2048=0, 3, 6; hit_cnt=0, err_cnt=0.
- seed_a=5, seed_b=7, num_vec=5, mode=2 -> pd_pattern1 alternates P/~P; hit_cnt=3, err_cnt=0.
- ones_o tied to 0, mode=0, num_vec=3 -> hit_cnt=0, err_cnt=3.
- ones_o tied to 0, mode=0, num_vec=255 -> err_cnt saturates at 255.
- rst_n pulsed low during RUN at idx=2 -> all outputs 0 immediately; a new start with num_vec=2 gives clean counts (hit_cnt=2 in mode 0).
- start pulsed during busy -> ignored: a single done pulse, counts reflect only the first run.
- num_vec=0 -> done the cycle after start, busy stays 0, counts 0.
